// File: rtl/sd_pkg.sv
// ---------------------------------------------------------------------------
// sd_pkg
// Shared definitions for the sequence-detector slice: the serializer FSM
// encoding, the word counter width, and the detector's own state constants.
// No ports; imported by sd_serializer and the modules around it.
// ---------------------------------------------------------------------------
package sd_pkg;

  // Serializer FSM encoding
  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_t;

  // Width of the completed-word counter
  localparam int WORD_CNT_W = 16;

  // Detector states, named after the prefix of the 1011 pattern matched so far
  typedef enum logic [2:0] {
    DET_ZERO     = 3'd0,
    DET_ONE      = 3'd1,
    DET_ONE_ZERO = 3'd2,
    DET_ONE_ZO   = 3'd3,
    DET_FOUND    = 3'd4
  } det_state_t;

endpackage

// File: rtl/sd_sat_counter.sv
// ---------------------------------------------------------------------------
// sd_sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clock    in   rising-edge clock
//   reset_n  in   asynchronous active-low clear
//   inc      in   count one on this edge (ignored once saturated)
//   count    out  current count, WIDTH bits
// ---------------------------------------------------------------------------
module sd_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Hold at all-ones so a long run never reads back as a small number
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sd_serializer.sv
// ---------------------------------------------------------------------------
// sd_serializer
// Parallel-to-serial stage feeding the detector's one-bit input. Words are
// accepted on a valid/ready handshake and shifted out one bit per clock with
// no gap between back-to-back words.
// Ports:
//   clock         in   rising-edge clock
//   reset_n       in   asynchronous active-low reset
//   data_in       in   WIDTH-bit word, sampled on handshake
//   data_valid    in   upstream offers data_in
//   data_ready    out  word accepted this cycle (combinational from state)
//   sequence_out  out  registered serial bit
//   bit_valid     out  sequence_out carries a data bit
//   busy          out  FSM in SHIFT
//   word_count    out  saturating count of fully shifted words
// ---------------------------------------------------------------------------
module sd_serializer
  import sd_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  sequence_out,
  output logic                  bit_valid,
  output logic                  busy,
  output logic [WORD_CNT_W-1:0] word_count
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  ser_state_t       state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic             last_bit;
  logic             handshake;

  // Bit that goes on the wire first for a given register image
  function automatic logic lead_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Move the next bit into the lead position
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign last_bit   = (state == SER_SHIFT) && (bit_cnt == LAST_BIT);
  // Ready opens during the last bit so the next word follows with no bubble
  assign data_ready = (state == SER_IDLE) || last_bit;
  assign handshake  = data_valid && data_ready;
  assign busy       = (state == SER_SHIFT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= SER_IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      sequence_out <= IDLE_BIT;
      bit_valid    <= 1'b0;
    end else begin
      if (handshake) begin
        state        <= SER_SHIFT;
        shreg        <= data_in;
        bit_cnt      <= '0;
        sequence_out <= lead_bit(data_in);
        bit_valid    <= 1'b1;
      end else if (state == SER_SHIFT) begin
        if (bit_cnt != LAST_BIT) begin
          shreg        <= shift_word(shreg);
          bit_cnt      <= bit_cnt + 1'b1;
          sequence_out <= lead_bit(shift_word(shreg));
        end else begin
          state        <= SER_IDLE;
          bit_cnt      <= '0;
          sequence_out <= IDLE_BIT;
          bit_valid    <= 1'b0;
        end
      end
    end
  end

  // A word counts when its last bit leaves the wire, whether or not another follows
  sd_sat_counter #(
    .WIDTH(WORD_CNT_W)
  ) u_word_count (
    .clock  (clock),
    .reset_n(reset_n),
    .inc    (last_bit),
    .count  (word_count)
  );

endmodule

// File: tb/tb_sd_serializer.sv
// ---------------------------------------------------------------------------
// tb_sd_serializer
// Directed bench for sd_serializer: an MSB-first instance, an LSB-first
// instance and a narrow stand-alone saturating counter.
// ---------------------------------------------------------------------------
module tb_sd_serializer;

  logic        clock;
  logic        reset_n;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        data_ready;
  logic        sequence_out;
  logic        bit_valid;
  logic        busy;
  logic [15:0] word_count;

  logic [7:0]  lsb_data;
  logic        lsb_valid;
  logic        lsb_ready;
  logic        lsb_seq;
  logic        lsb_bit_valid;
  logic        lsb_busy;
  logic [15:0] lsb_count;

  logic        sat_inc;
  logic [3:0]  sat_count;

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] stream;
  logic [7:0]  word;

  sd_serializer dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .sequence_out(sequence_out),
    .bit_valid   (bit_valid),
    .busy        (busy),
    .word_count  (word_count)
  );

  sd_serializer #(
    .WIDTH    (8),
    .MSB_FIRST(1'b0),
    .IDLE_BIT (1'b0)
  ) dut_lsb (
    .clock       (clock),
    .reset_n     (reset_n),
    .data_in     (lsb_data),
    .data_valid  (lsb_valid),
    .data_ready  (lsb_ready),
    .sequence_out(lsb_seq),
    .bit_valid   (lsb_bit_valid),
    .busy        (lsb_busy),
    .word_count  (lsb_count)
  );

  sd_sat_counter #(
    .WIDTH(4)
  ) u_sat (
    .clock  (clock),
    .reset_n(reset_n),
    .inc    (sat_inc),
    .count  (sat_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one full cycle; the bench always sits on the falling edge
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) @(negedge clock);
  endtask

  initial begin
    reset_n    = 1'b0;
    data_valid = 1'b1;
    data_in    = 8'hB0;
    lsb_valid  = 1'b0;
    lsb_data   = 8'h00;
    sat_inc    = 1'b0;

    // Reset held with valid asserted: nothing loads
    applyStimulus(3);
    checkOutput("rst_seq",   {31'd0, sequence_out}, 32'd0);
    checkOutput("rst_bv",    {31'd0, bit_valid},    32'd0);
    checkOutput("rst_busy",  {31'd0, busy},         32'd0);
    checkOutput("rst_cnt",   {16'd0, word_count},   32'd0);
    checkOutput("rst_ready", {31'd0, data_ready},   32'd1);
    checkOutput("rst_lsb_ready", {31'd0, lsb_ready}, 32'd1);

    reset_n = 1'b1;
    #1;
    checkOutput("rel_busy", {31'd0, busy},      32'd0);
    checkOutput("rel_bv",   {31'd0, bit_valid}, 32'd0);

    // Single word 8'hB0, MSB first
    applyStimulus(1);
    data_valid = 1'b0;
    word = 8'hB0;
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("b0_bit%0d", k), {31'd0, sequence_out}, {31'd0, word[7-k]});
      checkOutput($sformatf("b0_bv%0d", k),  {31'd0, bit_valid},    32'd1);
      checkOutput($sformatf("b0_rdy%0d", k), {31'd0, data_ready},   {31'd0, (k == 7)});
      applyStimulus(1);
    end
    checkOutput("b0_idle_seq", {31'd0, sequence_out}, 32'd0);
    checkOutput("b0_idle_bv",  {31'd0, bit_valid},    32'd0);
    checkOutput("b0_idle_busy",{31'd0, busy},         32'd0);
    checkOutput("b0_cnt",      {16'd0, word_count},   32'd1);

    // Back-to-back 8'hA5 then 8'h3C with valid held high
    data_valid = 1'b1;
    data_in    = 8'hA5;
    applyStimulus(1);
    data_in = 8'h3C;
    stream  = 16'hA53C;
    for (int k = 0; k < 16; k++) begin
      checkOutput($sformatf("b2b_bit%0d", k), {31'd0, sequence_out}, {31'd0, stream[15-k]});
      checkOutput($sformatf("b2b_bv%0d", k),  {31'd0, bit_valid},    32'd1);
      checkOutput($sformatf("b2b_rdy%0d", k), {31'd0, data_ready},
                  {31'd0, (k == 7) || (k == 15)});
      if (k == 8) checkOutput("b2b_cnt_mid", {16'd0, word_count}, 32'd2);
      applyStimulus(1);
      if (k == 7) data_valid = 1'b0;
    end
    checkOutput("b2b_idle_bv", {31'd0, bit_valid},  32'd0);
    checkOutput("b2b_cnt",     {16'd0, word_count}, 32'd3);

    // LSB-first instance with 8'h0D: 1,0,1,1,0,0,0,0
    lsb_valid = 1'b1;
    lsb_data  = 8'h0D;
    applyStimulus(1);
    lsb_valid = 1'b0;
    word = 8'b1011_0000;
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("lsb_bit%0d", k), {31'd0, lsb_seq},       {31'd0, word[7-k]});
      checkOutput($sformatf("lsb_bv%0d", k),  {31'd0, lsb_bit_valid}, 32'd1);
      applyStimulus(1);
    end
    checkOutput("lsb_idle_bv", {31'd0, lsb_bit_valid}, 32'd0);
    checkOutput("lsb_cnt",     {16'd0, lsb_count},     32'd1);

    // Reset mid-word after three bits of 8'hFF
    data_valid = 1'b1;
    data_in    = 8'hFF;
    applyStimulus(1);
    data_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("ff_bit%0d", k), {31'd0, sequence_out}, 32'd1);
      applyStimulus(1);
    end
    #2 reset_n = 1'b0;
    #1;
    checkOutput("mid_seq",   {31'd0, sequence_out}, 32'd0);
    checkOutput("mid_bv",    {31'd0, bit_valid},    32'd0);
    checkOutput("mid_busy",  {31'd0, busy},         32'd0);
    checkOutput("mid_cnt",   {16'd0, word_count},   32'd0);
    checkOutput("mid_ready", {31'd0, data_ready},   32'd1);
    applyStimulus(1);
    reset_n = 1'b1;
    checkOutput("mid_hold_cnt", {16'd0, word_count}, 32'd0);

    // Clean restart with 8'h81
    data_valid = 1'b1;
    data_in    = 8'h81;
    applyStimulus(1);
    data_valid = 1'b0;
    word = 8'h81;
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("rs_bit%0d", k), {31'd0, sequence_out}, {31'd0, word[7-k]});
      applyStimulus(1);
    end
    checkOutput("rs_cnt", {16'd0, word_count}, 32'd1);

    // Saturating counter: counts to 4'hF and sticks
    checkOutput("sat_start", {28'd0, sat_count}, 32'd0);
    sat_inc = 1'b1;
    applyStimulus(14);
    checkOutput("sat_14", {28'd0, sat_count}, 32'hE);
    applyStimulus(1);
    checkOutput("sat_15", {28'd0, sat_count}, 32'hF);
    applyStimulus(5);
    checkOutput("sat_hold", {28'd0, sat_count}, 32'hF);
    sat_inc = 1'b0;
    applyStimulus(2);
    checkOutput("sat_idle", {28'd0, sat_count}, 32'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
